// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external single-cycle ALU between two requesters.
//   Port 0 (execute stage) and port 1 (auxiliary user) each present a
//   valid/ready request (op, a, b) and receive a valid/ready response
//   (result, zero). Arbitration is round-robin; operands, op and the ALU
//   result are registered, so each operation takes IDLE -> EXEC -> RESP.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pX_req_valid/ready         request handshake for port X
//   pX_req_op/a/b              request payload for port X
//   pX_resp_valid/ready        response handshake for port X
//   pX_resp_result/zero        response payload for port X
//   alu_control/src_a/src_b    registered operands to the external ALU
//   alu_result/zero            combinational result from the external ALU
//   busy                       high whenever the FSM is not in IDLE
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic [OP_WIDTH-1:0]   p0_req_op,
  input  logic [DATA_WIDTH-1:0] p0_req_a,
  input  logic [DATA_WIDTH-1:0] p0_req_b,
  output logic                  p0_resp_valid,
  input  logic                  p0_resp_ready,
  output logic [DATA_WIDTH-1:0] p0_resp_result,
  output logic                  p0_resp_zero,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [OP_WIDTH-1:0]   p1_req_op,
  input  logic [DATA_WIDTH-1:0] p1_req_a,
  input  logic [DATA_WIDTH-1:0] p1_req_b,
  output logic                  p1_resp_valid,
  input  logic                  p1_resp_ready,
  output logic [DATA_WIDTH-1:0] p1_resp_result,
  output logic                  p1_resp_zero,
  output logic [OP_WIDTH-1:0]   alu_control,
  output logic [DATA_WIDTH-1:0] alu_src_a,
  output logic [DATA_WIDTH-1:0] alu_src_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state;
  logic                  grant;
  logic                  last_grant;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  resp0_q;
  logic                  resp1_q;
  logic                  busy_q;

  logic                  sel;
  logic                  take;
  logic                  resp_done;

  // Tie goes to the port that was not served last; a lone requester wins.
  // rst_n gates acceptance so no handshake is offered while reset is held.
  always_comb begin
    sel = 1'b0;
    if (p0_req_valid && p1_req_valid) sel = ~last_grant;
    else if (p1_req_valid)            sel = 1'b1;
    take      = (state == IDLE) && rst_n && (p0_req_valid || p1_req_valid);
    resp_done = grant ? p1_resp_ready : p0_resp_ready;
  end

  assign p0_req_ready   = take && !sel;
  assign p1_req_ready   = take && sel;

  assign alu_control    = op_q;
  assign alu_src_a      = a_q;
  assign alu_src_b      = b_q;

  assign p0_resp_valid  = resp0_q;
  assign p1_resp_valid  = resp1_q;
  assign p0_resp_result = result_q;
  assign p1_resp_result = result_q;
  assign p0_resp_zero   = zero_q;
  assign p1_resp_zero   = zero_q;
  assign busy           = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      resp0_q    <= 1'b0;
      resp1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            op_q   <= sel ? p1_req_op : p0_req_op;
            a_q    <= sel ? p1_req_a  : p0_req_a;
            b_q    <= sel ? p1_req_b  : p0_req_b;
            grant  <= sel;
            state  <= EXEC;
            busy_q <= 1'b1;
          end
        end
        EXEC: begin
          result_q <= alu_result;
          zero_q   <= alu_zero;
          resp0_q  <= ~grant;
          resp1_q  <= grant;
          state    <= RESP;
        end
        RESP: begin
          if (resp_done) begin
            last_grant <= grant;
            resp0_q    <= 1'b0;
            resp1_q    <= 1'b0;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp0_q <= 1'b0;
          resp1_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. A small behavioural ALU drives
// alu_result/alu_zero from the arbiter's registered operands; expected
// values in each test are hand-computed constants.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready;
  logic [2:0]  p0_req_op;
  logic [31:0] p0_req_a, p0_req_b;
  logic        p0_resp_valid, p0_resp_ready;
  logic [31:0] p0_resp_result;
  logic        p0_resp_zero;
  logic        p1_req_valid, p1_req_ready;
  logic [2:0]  p1_req_op;
  logic [31:0] p1_req_a, p1_req_b;
  logic        p1_resp_valid, p1_resp_ready;
  logic [31:0] p1_resp_result;
  logic        p1_resp_zero;
  logic [2:0]  alu_control;
  logic [31:0] alu_src_a, alu_src_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic p0_seen = 1'b0;

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_op(p0_req_op), .p0_req_a(p0_req_a), .p0_req_b(p0_req_b),
    .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready),
    .p0_resp_result(p0_resp_result), .p0_resp_zero(p0_resp_zero),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_op(p1_req_op), .p1_req_a(p1_req_a), .p1_req_b(p1_req_b),
    .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready),
    .p1_resp_result(p1_resp_result), .p1_resp_zero(p1_resp_zero),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-cycle ALU (MIPS-style control codes).
  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_src_a & alu_src_b;
      3'b001:  alu_result = alu_src_a | alu_src_b;
      3'b010:  alu_result = alu_src_a + alu_src_b;
      3'b100:  alu_result = alu_src_a & ~alu_src_b;
      3'b101:  alu_result = alu_src_a | ~alu_src_b;
      3'b110:  alu_result = alu_src_a - alu_src_b;
      3'b111:  alu_result = {31'b0, $signed(alu_src_a) < $signed(alu_src_b)};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  always @(negedge clk) if (p0_resp_valid === 1'b1) p0_seen = 1'b1;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  // Issues one request on a port (called in the clock-low phase) and returns
  // the response payload, the negedge count from handshake to resp_valid and
  // a timeout flag. Ends in the low phase after the response handshake.
  task automatic issue(input bit port, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z,
                       output int lat, output bit to);
    int n;
    to = 1'b0; res = '0; z = 1'b0; lat = 0; n = 0;
    if (port) begin
      p1_req_valid = 1'b1; p1_req_op = op; p1_req_a = a; p1_req_b = b; p1_resp_ready = 1'b1;
    end else begin
      p0_req_valid = 1'b1; p0_req_op = op; p0_req_a = a; p0_req_b = b; p0_resp_ready = 1'b1;
    end
    #1;
    while (!(port ? p1_req_ready : p0_req_ready) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    if (!(port ? p1_req_ready : p0_req_ready)) begin
      to = 1'b1;
      p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      p0_req_valid = 1'b0; p1_req_valid = 1'b0;
      while (!(port ? p1_resp_valid : p0_resp_valid) && lat < 8) begin
        @(negedge clk); lat++;
      end
      if (!(port ? p1_resp_valid : p0_resp_valid)) to = 1'b1;
      res = port ? p1_resp_result : p0_resp_result;
      z   = port ? p1_resp_zero   : p0_resp_zero;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    p0_req_valid = 0; p0_req_op = '0; p0_req_a = '0; p0_req_b = '0; p0_resp_ready = 0;
    p1_req_valid = 0; p1_req_op = '0; p1_req_a = '0; p1_req_b = '0; p1_resp_ready = 0;
    #1 rst_n = 1'b0;
    #2;
    tests++;
    if ({busy, p0_resp_valid, p1_resp_valid, p0_req_ready, p1_req_ready} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {busy, p0_resp_valid, p1_resp_valid, p0_req_ready, p1_req_ready});
    end
    tests++;
    if ({alu_control, alu_src_a, alu_src_b} !== 67'b0) begin
      fails++;
      $display("FAIL reset_alu_regs: got %h/%h/%h expected 0/0/0", alu_control, alu_src_a, alu_src_b);
    end
    tests++;
    if ({p0_resp_result, p0_resp_zero, p1_resp_zero} !== 34'b0) begin
      fail_line_res:
      begin
        fails++;
        $display("FAIL reset_result: got %h expected 0", p0_resp_result);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_port0();
    p0_req_valid = 1; p0_req_op = 3'b010; p0_req_a = 32'd5; p0_req_b = 32'd7; p0_resp_ready = 1;
    #1;
    tests++;
    if ({p0_req_ready, p1_req_ready, busy} !== 3'b100) begin
      fails++;
      $display("FAIL p0_handshake: got rdy0/rdy1/busy=%b expected 100", {p0_req_ready, p1_req_ready, busy});
    end
    @(negedge clk); p0_req_valid = 0; #1;
    tests++;
    if ({busy, p0_resp_valid} !== 2'b10 || alu_control !== 3'b010 || alu_src_a !== 32'd5 || alu_src_b !== 32'd7) begin
      fails++;
      $display("FAIL p0_exec: got busy=%b valid=%b op=%b a=%0d b=%0d expected busy=1 valid=0 op=010 a=5 b=7",
               busy, p0_resp_valid, alu_control, alu_src_a, alu_src_b);
    end
    @(negedge clk); #1;
    tests++;
    if ({p0_resp_valid, p1_resp_valid, busy} !== 3'b101 || p0_resp_result !== 32'd12 || p0_resp_zero !== 1'b0) begin
      fails++;
      $display("FAIL p0_resp: got v0=%b v1=%b busy=%b res=%0d z=%b expected v0=1 v1=0 busy=1 res=12 z=0",
               p0_resp_valid, p1_resp_valid, busy, p0_resp_result, p0_resp_zero);
    end
    @(negedge clk); #1;
    tests++;
    if ({busy, p0_resp_valid} !== 2'b00) begin
      fails++;
      $display("FAIL p0_done: got busy/valid=%b expected 00", {busy, p0_resp_valid});
    end
  endtask

  task automatic test_port1();
    logic [31:0] res; logic z; int lat; bit to;
    p0_seen = 1'b0;
    issue(1'b1, 3'b110, 32'd9, 32'd9, res, z, lat, to);
    tests++;
    if (to || lat != 2) begin
      fails++;
      $display("FAIL p1_latency: got timeout=%0d lat=%0d expected timeout=0 lat=2", to, lat);
    end
    tests++;
    if (res !== 32'd0 || z !== 1'b1) begin
      fails++;
      $display("FAIL p1_sub: got res=%0d z=%b expected res=0 z=1", res, z);
    end
    tests++;
    if (p0_seen !== 1'b0) begin
      fails++;
      $display("FAIL p1_no_p0_resp: got p0_resp_valid seen=%b expected 0", p0_seen);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit got;
    bit expg;
    rst_n = 1'b0;
    p0_req_valid = 1; p0_req_op = 3'b010; p0_req_a = 32'd3; p0_req_b = 32'd4; p0_resp_ready = 1;
    p1_req_valid = 1; p1_req_op = 3'b111; p1_req_a = 32'd2; p1_req_b = 32'd5; p1_resp_ready = 1;
    #1;
    tests++;
    if ({p0_req_ready, p1_req_ready} !== 2'b00) begin
      fails++;
      $display("FAIL rr_ready_in_reset: got %b expected 00", {p0_req_ready, p1_req_ready});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      expg = (k % 2) == 1;
      n = 0;
      while (!(p0_req_ready || p1_req_ready) && n < 8) begin
        @(negedge clk); #1; n++;
      end
      tests++;
      if ({p1_req_ready, p0_req_ready} !== (expg ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL rr_grant%0d: got rdy1/rdy0=%b expected %b", k,
                 {p1_req_ready, p0_req_ready}, expg ? 2'b10 : 2'b01);
      end
      got = p1_req_ready;
      @(negedge clk); @(negedge clk); #1;
      tests++;
      if ({p1_resp_valid, p0_resp_valid} !== (got ? 2'b10 : 2'b01) ||
          p0_resp_result !== (got ? 32'd1 : 32'd7)) begin
        fails++;
        $display("FAIL rr_result%0d: got v1/v0=%b res=%0d expected %b res=%0d", k,
                 {p1_resp_valid, p0_resp_valid}, p0_resp_result,
                 got ? 2'b10 : 2'b01, got ? 1 : 7);
      end
    end
    p0_req_valid = 0; p1_req_valid = 0;
    @(negedge clk); #1;
  endtask

  task automatic test_backpressure();
    p0_req_valid = 1; p0_req_op = 3'b001; p0_req_a = 32'hF0; p0_req_b = 32'h0F; p0_resp_ready = 0;
    p1_req_valid = 1; p1_req_op = 3'b010; p1_req_a = 32'd1; p1_req_b = 32'd1; p1_resp_ready = 1;
    #1;
    tests++;
    if ({p0_req_ready, p1_req_ready} !== 2'b10) begin
      fails++;
      $display("FAIL bp_grant: got rdy0/rdy1=%b expected 10", {p0_req_ready, p1_req_ready});
    end
    @(negedge clk); p0_req_valid = 0; #1;
    tests++;
    if (p1_req_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_exec_p1_ready: got %b expected 0", p1_req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      tests++;
      if (p0_resp_valid !== 1'b1 || p0_resp_result !== 32'h0000_00FF || p0_resp_zero !== 1'b0 || p1_req_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_stall%0d: got v=%b res=%h z=%b rdy1=%b expected v=1 res=000000ff z=0 rdy1=0",
                 i, p0_resp_valid, p0_resp_result, p0_resp_zero, p1_req_ready);
      end
    end
    p0_resp_ready = 1;
    @(negedge clk); #1;
    tests++;
    if ({p0_resp_valid, p1_req_ready} !== 2'b01) begin
      fails++;
      $display("FAIL bp_release: got v0/rdy1=%b expected 01", {p0_resp_valid, p1_req_ready});
    end
    @(posedge clk); #1; p1_req_valid = 0;
    @(negedge clk); @(negedge clk); #1;
    tests++;
    if (p1_resp_valid !== 1'b1 || p1_resp_result !== 32'd2) begin
      fails++;
      $display("FAIL bp_p1_result: got v=%b res=%0d expected v=1 res=2", p1_resp_valid, p1_resp_result);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic z; int lat; bit to;
    bit bad;
    p0_req_valid = 1; p0_req_op = 3'b010; p0_req_a = 32'd8; p0_req_b = 32'd8; p0_resp_ready = 1;
    @(posedge clk); #1; p0_req_valid = 0;
    tests++;
    if (busy !== 1'b1 || alu_src_a !== 32'd8) begin
      fails++;
      $display("FAIL mid_exec: got busy=%b a=%0d expected busy=1 a=8", busy, alu_src_a);
    end
    rst_n = 1'b0; #1;
    tests++;
    if ({busy, p0_resp_valid, p0_req_ready} !== 3'b0 || alu_src_a !== 32'd0 || alu_control !== 3'd0) begin
      fails++;
      $display("FAIL mid_async_reset: got busy=%b v=%b rdy=%b a=%0d op=%b expected all 0",
               busy, p0_resp_valid, p0_req_ready, alu_src_a, alu_control);
    end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (p0_resp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL mid_no_resp: got a response/busy after reset expected none");
    end
    issue(1'b0, 3'b010, 32'd1, 32'd1, res, z, lat, to);
    tests++;
    if (to || res !== 32'd2 || z !== 1'b0) begin
      fails++;
      $display("FAIL mid_recover: got timeout=%0d res=%0d z=%b expected timeout=0 res=2 z=0", to, res, z);
    end
  endtask

  task automatic test_slt();
    logic [31:0] res; logic z; int lat; bit to;
    issue(1'b0, 3'b111, 32'hFFFF_FFFE, 32'd1, res, z, lat, to);
    tests++;
    if (to || res !== 32'd1 || z !== 1'b0) begin
      fails++;
      $display("FAIL slt_neg: got timeout=%0d res=%0d z=%b expected timeout=0 res=1 z=0", to, res, z);
    end
    issue(1'b0, 3'b111, 32'd3, 32'd1, res, z, lat, to);
    tests++;
    if (to || res !== 32'd0 || z !== 1'b1) begin
      fails++;
      $display("FAIL slt_pos: got timeout=%0d res=%0d z=%b expected timeout=0 res=0 z=1", to, res, z);
    end
  endtask

  initial begin
    test_reset();
    test_port0();
    test_port1();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_slt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
